// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: reset base address,
// the ebreak word returned on illegal fetches, FSM state encoding and LFSR seed.
package imem_pkg;

    localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_EBREAK       = 32'h0010_0073;
    localparam logic [15:0] LFSR_SEED         = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_responder_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), right-shifting, seeded at reset.
// Steps once per cycle in which adv_i is high.
module lfsr16
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next state: shift right, feedback from the taps into bit 15.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // State register, returns to the seed on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, fixed latency LAT, word
// array filled via a loader side port. Illegal fetches return ebreak + err.
// Optional feature macro: IMEM_RAND_DELAY_EN adds 0..3 LFSR-driven wait cycles.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter logic [31:0] BASE  = IMEM_BASE_DEFAULT,
    parameter int unsigned LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        ld_wen,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = 5;  // holds LAT-1 plus up to 3 extra cycles
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    // Misaligned, or offset from BASE (32-bit wrap) beyond the array.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || ({1'b0, off} >= LIMIT);
    endfunction

    function automatic logic [AW-1:0] addr_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    logic [31:0]      mem_q [DEPTH];
    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_inst_q, rsp_inst_d;
    logic             rsp_err_q, rsp_err_d;
    logic             accept;
    logic             req_err;
    logic [AW-1:0]    req_idx;
    logic             ld_ok;
    logic [AW-1:0]    ld_idx;
    logic [CNT_W-1:0] load_cnt;

    assign req_err = addr_bad(req_addr);
    assign req_idx = addr_idx(req_addr);
    assign ld_ok   = ld_wen && !addr_bad(ld_addr);
    assign ld_idx  = addr_idx(ld_addr);

`ifdef IMEM_RAND_DELAY_EN
    logic [15:0] lfsr_st;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .adv_i   (accept),
        .state_o (lfsr_st)
    );

    assign unused_lfsr = ^lfsr_st[15:2];
    assign load_cnt    = CNT_W'(LAT - 1) + CNT_W'(lfsr_st[1:0]);
`else
    assign load_cnt    = CNT_W'(LAT - 1);
`endif

    // Next-state and response-register update; read happens at acceptance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_inst_d  = rsp_inst_q;
        rsp_err_d   = rsp_err_q;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    rsp_inst_d = req_err ? INST_EBREAK : mem_q[req_idx];
                    rsp_err_d  = req_err;
                    cnt_d      = load_cnt;
                    if (load_cnt == '0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d       = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset drops any in-flight fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_inst_q  <= rsp_inst_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Loader write port; a same-edge fetch still sees the old word.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_inst  = rsp_inst_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (LAT=3). Expected responses are
// predicted at acceptance and queued; works with or without IMEM_RAND_DELAY_EN.
module tb_imem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LAT   = 3;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
`ifdef IMEM_RAND_DELAY_EN
    localparam int NB2B = 64;
`else
    localparam int NB2B = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        ld_wen;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    imem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_err   (rsp_err),
        .ld_wen    (ld_wen),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [int];
    logic [15:0] lfsr_m = 16'hACE1;
    int          tests = 0;
    int          fails = 0;

    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] != 2'b00) || (off >= DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Reference prediction for a request accepted at the edge numbered acc.
    function automatic exp_t predict(input logic [31:0] a, input int acc);
        exp_t e;
        int   extra;
        extra = 0;
`ifdef IMEM_RAND_DELAY_EN
        extra  = int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
        e.err  = addr_bad(a);
        e.inst = e.err ? EBRK : mdl[widx(a)];
        e.acc  = acc;
        e.lat  = int'(LAT) + extra;
        return e;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_wen  = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_wen = 1'b0;
        if (!addr_bad(a)) mdl[widx(a)] = d;
    endtask

    // Waits for IDLE, presents one request, queues its prediction.
    task automatic issue(input logic [31:0] a);
        @(negedge clk);
        for (int k = 0; k < 40 && !req_ready; k++) @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        sb.push_back(predict(a, cyc + 1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output bit got, output int lat);
        got = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (sb.size() > 0) lat = cyc - sb[0].acc + 1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        ld_wen    = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (rsp_inst !== 32'h0) begin fails++; $display("FAIL reset_rsp_inst: got %h expected 0", rsp_inst); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        reset  = 1'b0;
        lfsr_m = 16'hACE1;
    endtask

    task automatic test_basic_fetch();
        bit   got;
        int   lat;
        exp_t e;
        load(BASE, 32'h0000_0413);
        issue(BASE);
        get_rsp(got, lat);
        e = sb.pop_front();
        tests++; if (!got) begin fails++; $display("FAIL basic_timeout: no rsp_valid within 40 cycles"); end
        tests++; if (lat !== e.lat) begin fails++; $display("FAIL basic_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (rsp_inst !== 32'h0000_0413) begin fails++; $display("FAIL basic_inst: got %h expected 00000413", rsp_inst); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b expected 0", rsp_err); end
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_back: got %b expected 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5];
        bit   got;
        int   lat;
        exp_t e;
        addrs[0] = BASE + 32'd2;
        addrs[1] = 32'h7FFF_FFFC;
        addrs[2] = BASE + DEPTH * 4;
        addrs[3] = BASE + DEPTH * 4 - 4;
        addrs[4] = BASE + 32'd1;
        load(BASE + DEPTH * 4 - 4, 32'hA5A5_0001);
        for (int i = 0; i < 5; i++) begin
            issue(addrs[i]);
            get_rsp(got, lat);
            e = sb.pop_front();
            tests++; if (!got) begin fails++; $display("FAIL err_timeout[%0d]: no rsp_valid", i); end
            tests++; if (rsp_inst !== e.inst) begin fails++; $display("FAIL err_inst[%0d]: got %h expected %h", i, rsp_inst, e.inst); end
            tests++; if (rsp_err !== e.err) begin fails++; $display("FAIL err_flag[%0d]: got %b expected %b", i, rsp_err, e.err); end
        end
    endtask

    task automatic test_backpressure();
        bit   got;
        int   lat;
        exp_t e;
        load(BASE + 32'h8, 32'hCAFE_0008);
        rsp_ready = 1'b0;
        issue(BASE + 32'h8);
        get_rsp(got, lat);
        e = sb.pop_front();
        tests++; if (!got) begin fails++; $display("FAIL bp_timeout: no rsp_valid"); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, rsp_valid); end
            tests++; if (rsp_inst !== e.inst) begin fails++; $display("FAIL bp_inst[%0d]: got %h expected %h", i, rsp_inst, e.inst); end
            tests++; if (rsp_err !== e.err) begin fails++; $display("FAIL bp_err[%0d]: got %b expected %b", i, rsp_err, e.err); end
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_rbw();
        bit   got;
        int   lat;
        exp_t e;
        load(BASE + 32'h10, 32'h1111_1111);
        load(BASE + 32'h14, 32'h2222_2222);
        // Fetch and loader write hit the same word on the same edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = BASE + 32'h10;
        ld_wen    = 1'b1;
        ld_addr   = BASE + 32'h10;
        ld_data   = 32'hDEAD_BEEF;
        sb.push_back(predict(BASE + 32'h10, cyc + 1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ld_wen    = 1'b0;
        mdl[widx(BASE + 32'h10)] = 32'hDEAD_BEEF;
        get_rsp(got, lat);
        e = sb.pop_front();
        tests++; if (rsp_inst !== 32'h1111_1111) begin fails++; $display("FAIL rbw_old: got %h expected 11111111", rsp_inst); end
        // Write during WAIT must not alter the in-flight response.
        issue(BASE + 32'h14);
        load(BASE + 32'h14, 32'h3333_3333);
        get_rsp(got, lat);
        e = sb.pop_front();
        tests++; if (rsp_inst !== 32'h2222_2222) begin fails++; $display("FAIL inflight_old: got %h expected 22222222", rsp_inst); end
        issue(BASE + 32'h10);
        get_rsp(got, lat);
        e = sb.pop_front();
        tests++; if (rsp_inst !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rbw_new: got %h expected deadbeef", rsp_inst); end
        issue(BASE + 32'h14);
        get_rsp(got, lat);
        e = sb.pop_front();
        tests++; if (rsp_inst !== 32'h3333_3333) begin fails++; $display("FAIL inflight_new: got %h expected 33333333", rsp_inst); end
    endtask

    task automatic test_reset_inflight();
        bit got;
        int lat;
        int seen;
        issue(BASE);
        @(negedge clk);
        @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_wait_busy: got %b expected 0", req_ready); end
        reset = 1'b1;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_valid: got %b expected 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_wait_ready: got %b expected 1", req_ready); end
        tests++; if (rsp_inst !== 32'h0) begin fails++; $display("FAIL rst_wait_inst: got %h expected 0", rsp_inst); end
        sb.delete();
        lfsr_m = 16'hACE1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_wait_ghost: got %0d responses expected 0", seen); end
        // Reset while holding a response in RESP.
        rsp_ready = 1'b0;
        issue(BASE);
        get_rsp(got, lat);
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL rst_resp_pre: got %b expected 1", rsp_valid); end
        reset = 1'b1;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b expected 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_resp_ready: got %b expected 1", req_ready); end
        sb.delete();
        lfsr_m = 16'hACE1;
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_resp_ghost: got %0d responses expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] a;
        int          issued   = 0;
        int          got      = 0;
        int          prev_acc = -1;
        int          prev_lat = 0;
        int          lat;
        for (int i = 0; i < NB2B; i++) load(BASE + 32'h100 + 32'(4 * i), $urandom);
        rsp_ready = 1'b1;
        for (int c = 0; c < NB2B * 12 + 50 && got < NB2B; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b2b_unexpected: response with empty queue, inst %h", rsp_inst);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc + 1;
                    tests++; if (rsp_inst !== e.inst) begin fails++; $display("FAIL b2b_inst[%0d]: got %h expected %h", got, rsp_inst, e.inst); end
                    tests++; if (rsp_err !== e.err) begin fails++; $display("FAIL b2b_err[%0d]: got %b expected %b", got, rsp_err, e.err); end
                    tests++; if (lat !== e.lat) begin fails++; $display("FAIL b2b_lat[%0d]: got %0d expected %0d", got, lat, e.lat); end
`ifdef IMEM_RAND_DELAY_EN
                    tests++; if (lat < int'(LAT) || lat > int'(LAT) + 3) begin fails++; $display("FAIL b2b_lat_range[%0d]: got %0d expected %0d..%0d", got, lat, LAT, LAT + 3); end
`endif
                end
                got++;
            end
            if (req_ready && issued < NB2B) begin
                a         = BASE + 32'h100 + 32'(4 * issued);
                req_valid = 1'b1;
                req_addr  = a;
                e         = predict(a, cyc + 1);
                if (prev_acc >= 0) begin
                    tests++;
                    if (cyc + 1 - prev_acc !== prev_lat + 1) begin
                        fails++;
                        $display("FAIL b2b_gap[%0d]: got %0d cycles expected %0d", issued, cyc + 1 - prev_acc, prev_lat + 1);
                    end
                end
                sb.push_back(e);
                prev_acc = cyc + 1;
                prev_lat = e.lat;
                issued++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        tests++; if (got !== NB2B) begin fails++; $display("FAIL b2b_count: got %0d responses expected %0d", got, NB2B); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_errors();
        test_backpressure();
        test_rbw();
        test_reset_inflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
